// File: rtl/intr_pkg.sv
// Shared types and helpers for the interrupt vectoring controller.
// Holds the FSM state encoding and the vector-width calculation used by the top and the encoder.
package intr_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_e;

  // A single source still needs a one-bit vector number.
  function automatic int calc_num_w(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

endpackage

// File: rtl/priority_encoder.sv
// Combinational priority encoder: reports the index of the winning set bit and whether any bit is set.
// LSB_HIGH_PRIORITY selects whether bit 0 or bit WIDTH-1 wins a tie.
module priority_encoder
  import intr_pkg::*;
#(
  parameter int WIDTH             = 32,
  parameter bit LSB_HIGH_PRIORITY = 1'b1,
  localparam int OUT_W            = calc_num_w(WIDTH)
) (
  input  logic [WIDTH-1:0] in_vec,
  output logic [OUT_W-1:0] out_num,
  output logic             out_valid
);

  // Scan from the low-priority end so the last hit is the winner.
  always_comb begin
    out_num   = '0;
    out_valid = 1'b0;
    if (LSB_HIGH_PRIORITY) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (in_vec[i]) begin
          out_num   = OUT_W'(i);
          out_valid = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (in_vec[i]) begin
          out_num   = OUT_W'(i);
          out_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/intr_vec_ctrl.sv
// Interrupt vectoring controller: latches per-source interrupts, masks them, and issues one vector
// at a time through a req/ack handshake with optional ack timeout and a programmable post-vector gap.
module intr_vec_ctrl
  import intr_pkg::*;
#(
  parameter int               PORTS       = 32,
  parameter logic [PORTS-1:0] EDGE_MODE   = {PORTS{1'b1}},
  parameter int               GAP_CYCLES  = 2,
  parameter int               ACK_TIMEOUT = 0,
  localparam int              NUM_W       = calc_num_w(PORTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] intr,
  input  logic [PORTS-1:0] intr_mask,
  input  logic             intr_vec_ack,
  output logic             intr_vec_req,
  output logic [NUM_W-1:0] intr_num,
  output logic [PORTS-1:0] intr_pending,
  output logic             intr_timeout
);

  localparam logic [7:0]  GAP_INIT   = 8'(GAP_CYCLES);
  localparam logic [15:0] TIMER_LAST = 16'(ACK_TIMEOUT - 1);
  localparam state_e      EXIT_STATE = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_e           state_q, state_d;
  logic [PORTS-1:0] intr_q;
  logic [PORTS-1:0] pending_q, pending_d;
  logic [PORTS-1:0] eligible;
  logic [PORTS-1:0] clear_vec;
  logic             req_q, req_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic             timeout_q, timeout_d;
  logic [15:0]      timer_q, timer_d;
  logic [7:0]       gap_q, gap_d;
  logic [NUM_W-1:0] enc_num;
  logic             enc_valid;
  logic             ack_clear;

  assign eligible = pending_q & ~intr_mask;

  priority_encoder #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (1'b1)
  ) u_prio (
    .in_vec    (eligible),
    .out_num   (enc_num),
    .out_valid (enc_valid)
  );

  // Edge sources hold until acked (a fresh edge beats the clear); level sources just follow the line.
  always_comb begin
    clear_vec = '0;
    pending_d = '0;
    for (int i = 0; i < PORTS; i++) begin
      clear_vec[i] = ack_clear && (num_q == NUM_W'(i));
      if (EDGE_MODE[i]) begin
        pending_d[i] = (intr[i] & ~intr_q[i]) | (pending_q[i] & ~clear_vec[i]);
      end else begin
        pending_d[i] = intr[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    num_d     = num_q;
    timeout_d = 1'b0;
    timer_d   = timer_q;
    gap_d     = gap_q;
    ack_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (enc_valid) begin
          req_d   = 1'b1;
          num_d   = enc_num;
          timer_d = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (intr_vec_ack) begin
          req_d     = 1'b0;
          num_d     = '0;
          ack_clear = 1'b1;
          gap_d     = GAP_INIT;
          state_d   = EXIT_STATE;
        end else if ((ACK_TIMEOUT != 0) && (timer_q == TIMER_LAST)) begin
          req_d     = 1'b0;
          num_d     = '0;
          timeout_d = 1'b1;
          gap_d     = GAP_INIT;
          state_d   = EXIT_STATE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      GAP: begin
        if (gap_q == 8'd1) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      intr_q    <= '0;
      pending_q <= '0;
      req_q     <= 1'b0;
      num_q     <= '0;
      timeout_q <= 1'b0;
      timer_q   <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      intr_q    <= intr;
      pending_q <= pending_d;
      req_q     <= req_d;
      num_q     <= num_d;
      timeout_q <= timeout_d;
      timer_q   <= timer_d;
      gap_q     <= gap_d;
    end
  end

  assign intr_vec_req = req_q;
  assign intr_num     = num_q;
  assign intr_pending = pending_q;
  assign intr_timeout = timeout_q;

endmodule
